// File: rtl/connect4_minimax_search.sv
// Depth-limited minimax search for 7x6 Connect Four, one tree node expanded per few enabled cycles.
// An explicit per-level stack holds the board, next column to try and the running best score for that level.
module connect4_minimax_search #(
  parameter int IS_ME = 1,
  parameter int DEPTH = 3
) (
  input  logic               w_clk,
  input  logic               w_rst,
  input  logic               w_en,
  input  logic [41:0]        i_me_field,
  input  logic [41:0]        i_op_field,
  input  logic [20:0]        i_piled_array,
  output logic               o_valid,
  output logic               o_finished,
  output logic signed [15:0] o_score,
  output logic [2:0]         o_selected_col
);

  localparam int LW = $clog2(DEPTH + 2);
  localparam logic signed [15:0] WIN_SCORE = 16'sd1000;
  localparam logic signed [15:0] NEG_INF   = -16'sd32767;
  localparam logic signed [15:0] POS_INF   = 16'sd32767;
  localparam logic ROOT_ME = (IS_ME != 0);

  typedef enum logic [2:0] {IDLE, LOAD, TRY, PLACE, CHECK, RETURN, DONE} state_t;

  typedef struct packed {
    logic [41:0]        me;
    logic [41:0]        op;
    logic [20:0]        h;
    logic [2:0]         cur;
    logic signed [15:0] best;
    logic [2:0]         bcol;
    logic               anyLegal;
  } entry_t;

  function automatic logic hasFour(input logic [41:0] b);
    logic f;
    f = 1'b0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 4; c++)
        f |= b[r*7+c] & b[r*7+c+1] & b[r*7+c+2] & b[r*7+c+3];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 7; c++)
        f |= b[r*7+c] & b[r*7+c+7] & b[r*7+c+14] & b[r*7+c+21];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        f |= b[r*7+c] & b[r*7+c+8] & b[r*7+c+16] & b[r*7+c+24];
    for (int r = 0; r < 3; r++)
      for (int c = 3; c < 7; c++)
        f |= b[r*7+c] & b[r*7+c+6] & b[r*7+c+12] & b[r*7+c+18];
    return f;
  endfunction

  function automatic logic [2:0] getH(input logic [20:0] h, input logic [2:0] c);
    logic [2:0] r;
    r = 3'd6;
    for (int k = 0; k < 7; k++)
      if (c == 3'(k)) r = h[k*3 +: 3];
    return r;
  endfunction

  function automatic logic [20:0] incH(input logic [20:0] h, input logic [2:0] c);
    logic [20:0] r;
    r = h;
    for (int k = 0; k < 7; k++)
      if (c == 3'(k)) r[k*3 +: 3] = h[k*3 +: 3] + 3'd1;
    return r;
  endfunction

  state_t state_q, state_d;
  entry_t stack_q [DEPTH+1];
  entry_t stack_d [DEPTH+1];
  logic [LW-1:0]      lv_q, lv_d;
  logic signed [15:0] ret_q, ret_d;
  logic               valid_q, valid_d, fin_q, fin_d;
  logic signed [15:0] score_q, score_d;
  logic [2:0]         col_q, col_d;

  entry_t     top, parent, child;
  logic       topMaxim, rootWin, childWin, atDepth, mergeEn;
  logic [2:0] topH;
  logic [41:0] placedBit;
  logic signed [15:0] mergeScore;

  // Level parity decides the mover: even levels belong to the root side.
  assign top       = stack_q[lv_q];
  assign parent    = stack_q[lv_q - LW'(1)];
  assign topMaxim  = ROOT_ME ^ lv_q[0];
  assign topH      = getH(top.h, top.cur);
  assign rootWin   = hasFour(i_me_field) | hasFour(i_op_field);
  assign childWin  = hasFour(topMaxim ? top.op : top.me);
  assign atDepth   = (lv_q == LW'(DEPTH));
  assign placedBit = 42'(1) << (int'(topH) * 7 + int'(top.cur));

  always_ff @(posedge w_clk) begin
    if (w_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (w_en) begin
      case (state_q)
        IDLE:   state_d = LOAD;
        LOAD:   state_d = rootWin ? DONE : TRY;
        TRY: begin
          if (top.cur == 3'd7)    state_d = (lv_q == '0) ? DONE : RETURN;
          else if (topH < 3'd6)   state_d = PLACE;
        end
        PLACE:  state_d = CHECK;
        CHECK:  state_d = TRY;
        RETURN: state_d = TRY;
        DONE:   state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stack_d    = stack_q;
    lv_d       = lv_q;
    ret_d      = ret_q;
    valid_d    = valid_q;
    fin_d      = fin_q;
    score_d    = score_q;
    col_d      = col_q;
    mergeEn    = 1'b0;
    mergeScore = '0;
    child      = top;
    if (w_en) begin
      case (state_q)
        LOAD: begin
          stack_d[0] = '{me: i_me_field, op: i_op_field, h: i_piled_array, cur: 3'd0,
                         best: (ROOT_ME ? NEG_INF : POS_INF), bcol: 3'd0, anyLegal: 1'b0};
          lv_d = '0;
        end
        TRY: begin
          if (top.cur == 3'd7)  ret_d = top.anyLegal ? top.best : 16'sd0;
          else if (topH >= 3'd6) stack_d[lv_q].cur = top.cur + 3'd1;
        end
        PLACE: begin
          child.me       = topMaxim ? (top.me | placedBit) : top.me;
          child.op       = topMaxim ? top.op : (top.op | placedBit);
          child.h        = incH(top.h, top.cur);
          child.cur      = 3'd0;
          child.best     = topMaxim ? POS_INF : NEG_INF;
          child.bcol     = 3'd0;
          child.anyLegal = 1'b0;
          stack_d[lv_q + LW'(1)]  = child;
          stack_d[lv_q].anyLegal  = 1'b1;
          lv_d = lv_q + LW'(1);
        end
        CHECK: begin
          if (childWin) begin
            mergeEn    = 1'b1;
            mergeScore = topMaxim ? -WIN_SCORE : WIN_SCORE;
          end else if (atDepth) begin
            mergeEn    = 1'b1;
            mergeScore = 16'sd0;
          end
        end
        RETURN: begin
          mergeEn    = 1'b1;
          mergeScore = ret_q;
        end
        default: ;
      endcase
      // Strict comparisons keep the lowest column on ties.
      if (mergeEn) begin
        if ((!topMaxim && mergeScore > parent.best) || (topMaxim && mergeScore < parent.best)) begin
          stack_d[lv_q - LW'(1)].best = mergeScore;
          stack_d[lv_q - LW'(1)].bcol = parent.cur;
        end
        stack_d[lv_q - LW'(1)].cur = parent.cur + 3'd1;
        lv_d = lv_q - LW'(1);
      end
      if (state_d == DONE && state_q != DONE) begin
        fin_d   = 1'b1;
        valid_d = stack_d[0].anyLegal;
        score_d = stack_d[0].anyLegal ? stack_d[0].best : 16'sd0;
        col_d   = stack_d[0].anyLegal ? stack_d[0].bcol : 3'd0;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      for (int i = 0; i <= DEPTH; i++) stack_q[i] <= '0;
      lv_q    <= '0;
      ret_q   <= '0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
      score_q <= '0;
      col_q   <= '0;
    end else begin
      stack_q <= stack_d;
      lv_q    <= lv_d;
      ret_q   <= ret_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
      score_q <= score_d;
      col_q   <= col_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_finished     = fin_q;
  assign o_score        = score_q;
  assign o_selected_col = col_q;

endmodule

// File: tb/tb_connect4_minimax_search.sv
// Scoreboard bench for the Connect Four minimax search: three parameterisations share stimulus,
// each search result is queued as expected and compared once the selected instance finishes.
module tb_connect4_minimax_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic [41:0] meF, opF;
  logic [20:0] piled;

  logic v0, f0, v1, f1, v2, f2;
  logic signed [15:0] s0, s1, s2;
  logic [2:0] c0, c1, c2;

  connect4_minimax_search #(.IS_ME(1), .DEPTH(3)) dutMax (
    .w_clk(clk), .w_rst(rst), .w_en(en), .i_me_field(meF), .i_op_field(opF),
    .i_piled_array(piled), .o_valid(v0), .o_finished(f0), .o_score(s0), .o_selected_col(c0));

  connect4_minimax_search #(.IS_ME(0), .DEPTH(3)) dutMin (
    .w_clk(clk), .w_rst(rst), .w_en(en), .i_me_field(meF), .i_op_field(opF),
    .i_piled_array(piled), .o_valid(v1), .o_finished(f1), .o_score(s1), .o_selected_col(c1));

  connect4_minimax_search #(.IS_ME(1), .DEPTH(1)) dutShallow (
    .w_clk(clk), .w_rst(rst), .w_en(en), .i_me_field(meF), .i_op_field(opF),
    .i_piled_array(piled), .o_valid(v2), .o_finished(f2), .o_score(s2), .o_selected_col(c2));

  int checkCount = 0;
  int failCount  = 0;

  typedef struct packed {
    logic [1:0]         inst;
    logic               fin;
    logic               valid;
    logic [2:0]         col;
    logic signed [15:0] score;
  } exp_t;

  exp_t sbQ[$];

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic readOut(input int inst, output logic f, output logic v,
                         output logic [2:0] c, output logic signed [15:0] s);
    case (inst)
      0:       begin f = f0; v = v0; c = c0; s = s0; end
      1:       begin f = f1; v = v1; c = c1; s = s1; end
      default: begin f = f2; v = v2; c = c2; s = s2; end
    endcase
  endtask

  task automatic setStone(inout logic [41:0] b, input int r, input int c);
    b[r*7+c] = 1'b1;
  endtask

  task automatic applyStimulus(input logic [41:0] me, input logic [41:0] op, input logic [20:0] h);
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    meF = me; opF = op; piled = h;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runSearch(input string tag, input int inst, input logic v, input logic [2:0] col,
                           input logic signed [15:0] sc, input bit randEn);
    exp_t e;
    logic f, ov;
    logic [2:0] oc;
    logic signed [15:0] os;
    int cyc, enCyc;
    bit done;
    sbQ.push_back('{inst: 2'(inst), fin: 1'b1, valid: v, col: col, score: sc});
    cyc = 0; enCyc = 0; done = 0;
    while (!done && cyc < 8000) begin
      en = randEn ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (en) enCyc++;
      readOut(inst, f, ov, oc, os);
      if (f) done = 1;
    end
    en = 1'b0;
    if (!done) checkOutput({tag, "_timeout"}, 0, 1);
    e = sbQ.pop_front();
    readOut(int'(e.inst), f, ov, oc, os);
    checkOutput({tag, "_finished"}, int'(f), int'(e.fin));
    checkOutput({tag, "_valid"}, int'(ov), int'(e.valid));
    checkOutput({tag, "_col"}, int'(oc), int'(e.col));
    checkOutput({tag, "_score"}, int'(os), int'(e.score));
    if (!randEn) checkOutput({tag, "_latency_le_1500"}, int'(enCyc <= 1500), 1);
    en = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b0;
    readOut(int'(e.inst), f, ov, oc, os);
    checkOutput({tag, "_hold_col"}, int'(oc), int'(e.col));
    checkOutput({tag, "_hold_score"}, int'(os), int'(e.score));
  endtask

  task automatic checkCleared(input string tag);
    logic f, v;
    logic [2:0] c;
    logic signed [15:0] s;
    readOut(0, f, v, c, s);
    checkOutput({tag, "_finished"}, int'(f), 0);
    checkOutput({tag, "_valid"}, int'(v), 0);
    checkOutput({tag, "_col"}, int'(c), 0);
    checkOutput({tag, "_score"}, int'(s), 0);
  endtask

  logic [41:0] me1, op1, me2, op2, meFull, opFull, meWin;
  logic [20:0] h1, h2, hFull, hWin;

  initial begin
    rst = 1'b1; en = 1'b0; meF = '0; opF = '0; piled = '0;
    repeat (2) @(negedge clk);
    checkCleared("reset");
    rst = 1'b0;

    me1 = '0; op1 = '0;
    setStone(me1, 0, 0); setStone(me1, 1, 0);
    setStone(op1, 0, 1); setStone(op1, 1, 1); setStone(op1, 2, 1);
    h1 = '0; h1[2:0] = 3'd2; h1[5:3] = 3'd3;

    me2 = '0; op2 = '0;
    setStone(me2, 0, 0); setStone(me2, 1, 0); setStone(me2, 2, 0);
    setStone(op2, 0, 2); setStone(op2, 1, 2);
    h2 = '0; h2[2:0] = 3'd3; h2[8:6] = 3'd2;

    meFull = '0; opFull = '0; hFull = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if ((((r / 2) + c) % 2) == 0) setStone(meFull, r, c);
        else                          setStone(opFull, r, c);
    for (int c = 0; c < 7; c++) hFull[c*3 +: 3] = 3'd6;

    meWin = '0; hWin = '0;
    for (int r = 0; r < 4; r++) setStone(meWin, r, 0);
    hWin[2:0] = 3'd4;

    applyStimulus(me1, op1, h1);
    runSearch("block_threat", 0, 1'b1, 3'd1, 16'sd0, 1'b0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkCleared("reset_after_done");

    applyStimulus(me2, op2, h2);
    runSearch("me_wins", 0, 1'b1, 3'd0, 16'sd1000, 1'b0);

    applyStimulus(me1, op1, h1);
    runSearch("op_wins_root", 1, 1'b1, 3'd1, -16'sd1000, 1'b0);

    applyStimulus('0, '0, '0);
    runSearch("empty_depth1", 2, 1'b1, 3'd0, 16'sd0, 1'b0);

    applyStimulus(meFull, opFull, hFull);
    runSearch("full_board", 0, 1'b0, 3'd0, 16'sd0, 1'b0);

    applyStimulus(meWin, '0, hWin);
    runSearch("root_has_four", 0, 1'b0, 3'd0, 16'sd0, 1'b0);

    applyStimulus(me1, op1, h1);
    en = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("mid_search_not_finished", int'(f0), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    checkCleared("mid_reset");
    applyStimulus(me1, op1, h1);
    runSearch("rerun_after_reset", 0, 1'b1, 3'd1, 16'sd0, 1'b0);

    applyStimulus(me2, op2, h2);
    runSearch("me_wins_random_en", 0, 1'b1, 3'd0, 16'sd1000, 1'b1);
    applyStimulus(me1, op1, h1);
    runSearch("block_threat_random_en", 0, 1'b1, 3'd1, 16'sd0, 1'b1);

    applyStimulus(me1, op1, h1);
    en = 1'b0;
    repeat (2000) @(negedge clk);
    checkOutput("en_low_not_finished", int'(f0), 0);
    checkOutput("en_low_shallow_not_finished", int'(f2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
